alu_mc: RTL and testbench

- Parametrised, multi-cycle successor to the 8-bit CPU ALU.
- Keeps the single-cycle logic/arithmetic op set, widened to WIDTH bits.
- Adds a signed-overflow flag, a signed compare flag, variable-count shifts and an unsigned shift-add multiplier.
- Sits between the register file and the writeback/flag register; the control unit issues ops with a valid/ready handshake and stalls on in_ready.

---
 rtl/alu_pkg.sv | 49 ++++
 rtl/alu_mc_comb.sv | 75 +++++++
 rtl/alu_mc.sv | 194 +++++++++++++++++++
 tb/tb_alu_mc.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM states and the
// layout of the {carry, zero, negative, overflow} flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_PASSA = 4'h0;
    localparam logic [3:0] OP_AND   = 4'h1;
    localparam logic [3:0] OP_OR    = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_ADC   = 4'h5;
    localparam logic [3:0] OP_CMP   = 4'h6;
    localparam logic [3:0] OP_SUB   = 4'h7;
    localparam logic [3:0] OP_SBB   = 4'h8;
    localparam logic [3:0] OP_NOT   = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_SHR   = 4'hB;
    localparam logic [3:0] OP_SAR   = 4'hC;
    localparam logic [3:0] OP_MUL   = 4'hD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

    // Flag bundle bit positions; the bundle reads {c, z, n, v} MSB first.
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 0;
    localparam int NFLAGS = 4;

    typedef logic [NFLAGS-1:0] flags_t;

    function automatic logic is_shift(input logic [3:0] m);
        return (m == OP_SHL) || (m == OP_SHR) || (m == OP_SAR);
    endfunction

    function automatic flags_t make_flags(input logic c, input logic z,
                                          input logic n, input logic v);
        flags_t f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_mc_comb.sv
// Single-cycle op set and flag generation. Shift/MUL codes fall through as a
// pass of A with carry=cin, which is exactly the zero-count shift result.
module alu_mc_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] res,
    output flags_t           flags
);

    localparam int MSB = WIDTH - 1;

    logic             add_cin;
    logic             sub_bin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             add_v;
    logic             sub_v;
    logic             c;
    logic             z;
    logic             n;
    logic             v;

    assign add_cin = (mode == OP_ADC) & cin;
    assign sub_bin = (mode == OP_SBB) & cin;
    assign sum     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    // The extra top bit of the difference is the borrow out.
    assign diff    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_bin};
    assign add_v   = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
    assign sub_v   = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);

    always_comb begin
        res = '0;
        c   = cin;
        v   = 1'b0;
        case (mode)
            OP_PASSA: res = a;
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_ADD, OP_ADC: begin
                res = sum[MSB:0];
                c   = sum[WIDTH];
                v   = add_v;
            end
            OP_CMP:   res = a;
            OP_SUB, OP_SBB: begin
                res = diff[MSB:0];
                c   = diff[WIDTH];
                v   = sub_v;
            end
            OP_NOT:   res = ~a;
            OP_SHL, OP_SHR, OP_SAR, OP_MUL: res = a;
            default:  res = '0;
        endcase

        z = (res == '0);
        n = res[MSB];

        if (mode == OP_CMP) begin
            c = (a < b);
            z = (a == b);
            n = ($signed(a) < $signed(b));
            v = 1'b0;
        end

        flags = make_flags(c, z, n, v);
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops via alu_mc_comb, plus bit-serial shifts
// and a shift-add unsigned multiplier sequenced by a two-state FSM.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       mode,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic             cin,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             cout,
    output logic             zout,
    output logic             nout,
    output logic             vout
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam int MSB = WIDTH - 1;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] mplr_q, mplr_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] out_hi_q, out_hi_d;
    flags_t           flags_q, flags_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] comb_res;
    flags_t           comb_flags;
    logic             accept;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sh_next;
    logic             sh_bit;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH-1:0] mul_lo_next;

    alu_mc_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .mode  (mode),
        .a     (dataA),
        .b     (dataB),
        .cin   (cin),
        .res   (comb_res),
        .flags (comb_flags)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign shamt    = dataB[SHW-1:0];

    // One-bit shift step on the working register; sh_bit is the bit leaving it.
    always_comb begin
        sh_next = work_q;
        sh_bit  = 1'b0;
        case (op_q)
            OP_SHL: begin
                sh_next = {work_q[MSB-1:0], 1'b0};
                sh_bit  = work_q[MSB];
            end
            OP_SHR: begin
                sh_next = {1'b0, work_q[MSB:1]};
                sh_bit  = work_q[0];
            end
            OP_SAR: begin
                sh_next = {work_q[MSB], work_q[MSB:1]};
                sh_bit  = work_q[0];
            end
            default: begin
                sh_next = work_q;
                sh_bit  = 1'b0;
            end
        endcase
    end

    // Multiplier step: {acc, mplr} shifts right one place while the
    // multiplicand (held in work_q) is conditionally added into acc.
    assign mul_sum      = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, work_q} : {(WIDTH+1){1'b0}});
    assign mul_acc_next = mul_sum[WIDTH:1];
    assign mul_lo_next  = {mul_sum[0], mplr_q[MSB:1]};

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        mplr_d   = mplr_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        flags_d  = flags_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d = mode;
                    if (mode == OP_MUL) begin
                        work_d  = dataA;
                        mplr_d  = dataB;
                        acc_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = ST_ITER;
                    end else if (is_shift(mode) && (shamt != '0)) begin
                        work_d  = dataA;
                        cnt_d   = {1'b0, shamt};
                        state_d = ST_ITER;
                    end else begin
                        out_d    = comb_res;
                        out_hi_d = '0;
                        flags_d  = comb_flags;
                        done_d   = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d  = mul_acc_next;
                    mplr_d = mul_lo_next;
                    if (cnt_q == CW'(1)) begin
                        out_d    = mul_lo_next;
                        out_hi_d = mul_acc_next;
                        flags_d  = make_flags(|mul_acc_next,
                                              ({mul_acc_next, mul_lo_next} == '0),
                                              mul_lo_next[MSB], 1'b0);
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end else begin
                    work_d = sh_next;
                    if (cnt_q == CW'(1)) begin
                        out_d    = sh_next;
                        out_hi_d = '0;
                        flags_d  = make_flags(sh_bit, (sh_next == '0),
                                              sh_next[MSB], 1'b0);
                        done_d   = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_PASSA;
            work_q   <= '0;
            mplr_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            mplr_q   <= mplr_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
        end
    end

    // Gating with rst keeps done low even if reset rises mid-cycle.
    assign done   = done_q & ~rst;
    assign out    = out_q;
    assign out_hi = out_hi_q;
    assign cout   = flags_q[FLAG_C];
    assign zout   = flags_q[FLAG_Z];
    assign nout   = flags_q[FLAG_N];
    assign vout   = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH 8, 16 and 32 sharing one clock and bus.
module tb_alu_mc;

    logic        clk;
    logic        rst;
    logic        v8, v16, v32;
    logic [3:0]  mode;
    logic [31:0] dA, dB;
    logic        cin;

    logic        rdy8, rdy16, rdy32;
    logic        done8, done16, done32;
    logic [7:0]  out8, hi8;
    logic [15:0] out16, hi16;
    logic [31:0] out32, hi32;
    logic        c8, z8, n8, vf8, c16, z16, n16, vf16, c32, z32, n32, vf32;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sel_w    = 8;

    logic [31:0] sel_out, sel_hi;
    logic [3:0]  sel_flags;
    logic        sel_done, sel_ready;

    alu_mc #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .mode(mode),
        .dataA(dA[7:0]), .dataB(dB[7:0]), .cin(cin), .done(done8),
        .out(out8), .out_hi(hi8), .cout(c8), .zout(z8), .nout(n8), .vout(vf8));

    alu_mc #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v16), .in_ready(rdy16), .mode(mode),
        .dataA(dA[15:0]), .dataB(dB[15:0]), .cin(cin), .done(done16),
        .out(out16), .out_hi(hi16), .cout(c16), .zout(z16), .nout(n16), .vout(vf16));

    alu_mc #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32), .mode(mode),
        .dataA(dA), .dataB(dB), .cin(cin), .done(done32),
        .out(out32), .out_hi(hi32), .cout(c32), .zout(z32), .nout(n32), .vout(vf32));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        sel_out   = {24'h0, out8};
        sel_hi    = {24'h0, hi8};
        sel_flags = {c8, z8, n8, vf8};
        sel_done  = done8;
        sel_ready = rdy8;
        if (sel_w == 16) begin
            sel_out   = {16'h0, out16};
            sel_hi    = {16'h0, hi16};
            sel_flags = {c16, z16, n16, vf16};
            sel_done  = done16;
            sel_ready = rdy16;
        end else if (sel_w == 32) begin
            sel_out   = out32;
            sel_hi    = hi32;
            sel_flags = {c32, z32, n32, vf32};
            sel_done  = done32;
            sel_ready = rdy32;
        end
    end

    // Issue one op to the selected instance and wait (bounded) for done.
    // lat = negedges from accept to the first one showing done (-1 on timeout);
    // busy = negedges with in_ready low before done.
    task automatic run(input int w, input logic [3:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input bit scramble,
                       output int lat, output int busy);
        sel_w = w;
        @(negedge clk);
        mode = m; dA = a; dB = b; cin = c;
        v8 = (w == 8); v16 = (w == 16); v32 = (w == 32);
        @(posedge clk);
        #1;
        v8 = 1'b0; v16 = 1'b0; v32 = 1'b0;
        lat = -1; busy = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (sel_done) begin
                lat = k;
                break;
            end
            if (!sel_ready) busy++;
            if (scramble) begin
                dA = $urandom; dB = $urandom; mode = 4'($urandom);
            end
        end
        $display("txn w=%0d mode=%h a=%h b=%h cin=%b -> out=%h hi=%h cznv=%b lat=%0d busy=%0d",
                 w, m, a, b, c, sel_out, sel_hi, sel_flags, lat, busy);
    endtask

    task automatic test_reset();
        rst = 1'b1; v8 = 0; v16 = 0; v32 = 0; mode = 4'h0; dA = '0; dB = '0; cin = 0;
        sel_w = 8;
        repeat (3) @(negedge clk);
        n_checks++; if (sel_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", sel_ready); end
        n_checks++; if (sel_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", sel_done); end
        n_checks++; if ({sel_hi, sel_out, sel_flags} !== 68'h0) begin n_fail++; $display("FAIL reset_outs: got hi=%h out=%h cznv=%b want all 0", sel_hi, sel_out, sel_flags); end
        n_checks++; if ({out16, hi16, out32, hi32, done16, done32} !== 98'h0) begin n_fail++; $display("FAIL reset_wide: got out16=%h out32=%h want 0", out16, out32); end
        rst = 1'b0;
    endtask

    task automatic test_add();
        int lat, busy;
        run(8, 4'h4, 32'h7F, 32'h01, 1'b0, 1'b0, lat, busy);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_checks++; if (sel_out !== 32'h80) begin n_fail++; $display("FAIL add_out: got %h want 80", sel_out); end
        n_checks++; if (sel_flags !== 4'b0011) begin n_fail++; $display("FAIL add_flags: got cznv=%b want 0011", sel_flags); end
        @(negedge clk);
        n_checks++; if (sel_done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b want 0", sel_done); end
    endtask

    task automatic test_sbb_cmp();
        int lat, busy;
        run(8, 4'h8, 32'h00, 32'h00, 1'b1, 1'b0, lat, busy);
        n_checks++; if (sel_out !== 32'hFF) begin n_fail++; $display("FAIL sbb_out: got %h want ff", sel_out); end
        n_checks++; if (sel_flags !== 4'b1010) begin n_fail++; $display("FAIL sbb_flags: got cznv=%b want 1010", sel_flags); end
        run(8, 4'h6, 32'h80, 32'h01, 1'b0, 1'b0, lat, busy);
        n_checks++; if (sel_out !== 32'h80) begin n_fail++; $display("FAIL cmp_out: got %h want 80", sel_out); end
        n_checks++; if (sel_flags !== 4'b0010) begin n_fail++; $display("FAIL cmp_flags: got cznv=%b want 0010", sel_flags); end
    endtask

    task automatic test_shift();
        int lat, busy;
        run(8, 4'hC, 32'h90, 32'h03, 1'b1, 1'b0, lat, busy);
        n_checks++; if (busy != 3 || lat != 4) begin n_fail++; $display("FAIL sar3_timing: got busy=%0d lat=%0d want 3/4", busy, lat); end
        n_checks++; if ({sel_out, sel_flags} !== {32'hF2, 4'b0010}) begin n_fail++; $display("FAIL sar3_result: got out=%h cznv=%b want f2/0010", sel_out, sel_flags); end
        run(8, 4'hA, 32'h81, 32'h00, 1'b1, 1'b0, lat, busy);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL shl0_latency: got %0d want 1", lat); end
        n_checks++; if ({sel_out, sel_flags} !== {32'h81, 4'b1010}) begin n_fail++; $display("FAIL shl0_result: got out=%h cznv=%b want 81/1010", sel_out, sel_flags); end
        run(8, 4'hA, 32'h81, 32'h01, 1'b0, 1'b0, lat, busy);
        n_checks++; if ({sel_out, sel_flags, lat} !== {32'h02, 4'b1000, 32'd2}) begin n_fail++; $display("FAIL shl1: got out=%h cznv=%b lat=%0d want 02/1000/2", sel_out, sel_flags, lat); end
        run(8, 4'hB, 32'h80, 32'h07, 1'b1, 1'b0, lat, busy);
        n_checks++; if ({sel_out, sel_flags} !== {32'h01, 4'b0000}) begin n_fail++; $display("FAIL shr7: got out=%h cznv=%b want 01/0000", sel_out, sel_flags); end
        run(8, 4'hC, 32'h80, 32'h07, 1'b1, 1'b0, lat, busy);
        n_checks++; if ({sel_out, sel_flags, lat} !== {32'hFF, 4'b0010, 32'd8}) begin n_fail++; $display("FAIL sar7: got out=%h cznv=%b lat=%0d want ff/0010/8", sel_out, sel_flags, lat); end
    endtask

    task automatic test_mul();
        int lat, busy;
        run(8, 4'hD, 32'hFF, 32'hFF, 1'b0, 1'b0, lat, busy);
        n_checks++; if (busy != 8 || lat != 9) begin n_fail++; $display("FAIL mul_timing: got busy=%0d lat=%0d want 8/9", busy, lat); end
        n_checks++; if ({sel_hi, sel_out, sel_flags} !== {32'hFE, 32'h01, 4'b1000}) begin n_fail++; $display("FAIL mul_ff: got hi=%h out=%h cznv=%b want fe/01/1000", sel_hi, sel_out, sel_flags); end
        run(8, 4'hD, 32'h00, 32'h55, 1'b0, 1'b0, lat, busy);
        n_checks++; if ({sel_hi, sel_out, sel_flags} !== {32'h0, 32'h0, 4'b0100}) begin n_fail++; $display("FAIL mul_zero: got hi=%h out=%h cznv=%b want 0/0/0100", sel_hi, sel_out, sel_flags); end
    endtask

    task automatic test_operand_change();
        int lat, busy;
        run(8, 4'hD, 32'h0D, 32'h0B, 1'b0, 1'b1, lat, busy);
        n_checks++; if ({sel_hi, sel_out, sel_flags, lat} !== {32'h0, 32'h8F, 4'b0010, 32'd9}) begin n_fail++; $display("FAIL mul_scramble: got hi=%h out=%h cznv=%b lat=%0d want 0/8f/0010/9", sel_hi, sel_out, sel_flags, lat); end
    endtask

    task automatic test_reset_mid();
        int lat, busy;
        bit saw_done;
        sel_w = 8;
        saw_done = 1'b0;
        @(negedge clk);
        mode = 4'hD; dA = 32'hFF; dB = 32'hFF; cin = 1'b0; v8 = 1'b1;
        @(posedge clk);
        #1 v8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (sel_done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({sel_ready, sel_done} !== 2'b10) begin n_fail++; $display("FAIL rstmid_handshake: got ready=%b done=%b want 1/0", sel_ready, sel_done); end
        n_checks++; if ({sel_hi, sel_out, sel_flags} !== 68'h0) begin n_fail++; $display("FAIL rstmid_outs: got hi=%h out=%h cznv=%b want all 0", sel_hi, sel_out, sel_flags); end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (sel_done) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_done: got done seen=%b want 0", saw_done); end
        run(8, 4'h4, 32'h02, 32'h03, 1'b0, 1'b0, lat, busy);
        n_checks++; if ({sel_out, sel_flags, lat} !== {32'h05, 4'b0000, 32'd1}) begin n_fail++; $display("FAIL rstmid_add: got out=%h cznv=%b lat=%0d want 05/0000/1", sel_out, sel_flags, lat); end
    endtask

    task automatic test_back_to_back();
        sel_w = 8;
        @(negedge clk);
        mode = 4'h3; dA = 32'hF0; dB = 32'h3C; cin = 1'b0; v8 = 1'b1;
        @(posedge clk);
        #1 mode = 4'h2; dA = 32'h0F; dB = 32'h30;
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        $display("txn w=8 b2b second-sample out=%h done=%b", sel_out, sel_done);
        n_checks++; if ({sel_done, sel_out} !== {1'b1, 32'h3F}) begin n_fail++; $display("FAIL b2b_or: got done=%b out=%h want 1/3f", sel_done, sel_out); end
        @(negedge clk);
        n_checks++; if (sel_done !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got done=%b want 0", sel_done); end
    endtask

    // Separate XOR sample: check the first back-to-back result between edges.
    task automatic test_back_to_back_first();
        sel_w = 8;
        @(negedge clk);
        mode = 4'h3; dA = 32'hF0; dB = 32'h3C; cin = 1'b0; v8 = 1'b1;
        @(posedge clk);
        #1 mode = 4'h2; dA = 32'h0F; dB = 32'h30;
        @(negedge clk);
        $display("txn w=8 b2b first-sample out=%h done=%b", sel_out, sel_done);
        n_checks++; if ({sel_done, sel_out} !== {1'b1, 32'hCC}) begin n_fail++; $display("FAIL b2b_xor: got done=%b out=%h want 1/cc", sel_done, sel_out); end
        @(posedge clk);
        #1 v8 = 1'b0;
        @(negedge clk);
        n_checks++; if ({sel_done, sel_out} !== {1'b1, 32'h3F}) begin n_fail++; $display("FAIL b2b_or2: got done=%b out=%h want 1/3f", sel_done, sel_out); end
        @(negedge clk);
    endtask

    function automatic longint sx(input longint unsigned val, input int w);
        longint unsigned half;
        half = 64'd1 << (w - 1);
        if ((val & half) != 0) return longint'(val) - longint'(half << 1);
        return longint'(val);
    endfunction

    task automatic test_wide(input int w);
        longint unsigned msk, half, a, b, r, eo, ehi;
        longint          ss;
        logic            ec, ez, en, ev;
        logic [3:0]      m;
        int              lat, busy, elat;
        msk  = (64'd1 << w) - 1;
        half = 64'd1 << (w - 1);
        for (int op = 0; op < 3; op++) begin
            for (int i = 0; i < 6; i++) begin
                if (i == 0) begin
                    a = (op == 0) ? half - 1 : (op == 1) ? half : msk;
                    b = (op == 2) ? msk : 64'd1;
                end else begin
                    a = longint'($urandom) & msk;
                    b = longint'($urandom) & msk;
                end
                m = (op == 0) ? 4'h4 : (op == 1) ? 4'h7 : 4'hD;
                run(w, m, a[31:0], b[31:0], 1'b0, 1'b0, lat, busy);
                ehi = 0; ev = 1'b0;
                if (op == 0) begin
                    r  = a + b;
                    eo = r & msk;
                    ec = ((r >> w) & 1) != 0;
                    ss = sx(a, w) + sx(b, w);
                    ev = (ss >= longint'(half)) || (ss < -longint'(half));
                    ez = (eo == 0);
                end else if (op == 1) begin
                    r  = a - b;
                    eo = r & msk;
                    ec = (a < b);
                    ss = sx(a, w) - sx(b, w);
                    ev = (ss >= longint'(half)) || (ss < -longint'(half));
                    ez = (eo == 0);
                end else begin
                    r   = a * b;
                    eo  = r & msk;
                    ehi = (r >> w) & msk;
                    ec  = (ehi != 0);
                    ez  = (r == 0);
                end
                en   = ((eo >> (w - 1)) & 1) != 0;
                elat = (op == 2) ? w + 1 : 1;
                n_checks++;
                if ({sel_hi, sel_out, sel_flags} !== {ehi[31:0], eo[31:0], ec, ez, en, ev}) begin
                    n_fail++;
                    $display("FAIL wide%0d_result op=%h a=%h b=%h: got hi=%h out=%h cznv=%b want hi=%h out=%h cznv=%b",
                             w, m, a, b, sel_hi, sel_out, sel_flags, ehi[31:0], eo[31:0], {ec, ez, en, ev});
                end
                n_checks++;
                if (lat != elat) begin
                    n_fail++;
                    $display("FAIL wide%0d_latency op=%h: got %0d want %0d", w, m, lat, elat);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sbb_cmp();
        test_shift();
        test_mul();
        test_operand_change();
        test_reset_mid();
        test_back_to_back_first();
        test_back_to_back();
        test_wide(16);
        test_wide(32);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
